// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 16-bit ALU between two requesters, with
// per-requester ownership lock and a one-entry response register tagged by id.
module alu_arbiter #(
   parameter int unsigned OP_WIDTH = 2
) (
   input  logic                clk,
   input  logic                reset,

   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic [15:0]         req0_a,
   input  logic [15:0]         req0_b,
   input  logic [OP_WIDTH-1:0] req0_op,
   input  logic                req0_lock,

   input  logic                req1_valid,
   output logic                req1_ready,
   input  logic [15:0]         req1_a,
   input  logic [15:0]         req1_b,
   input  logic [OP_WIDTH-1:0] req1_op,
   input  logic                req1_lock,

   output logic [15:0]         alu_a,
   output logic [15:0]         alu_b,
   output logic [OP_WIDTH-1:0] alu_op,
   input  logic [15:0]         alu_out,

   output logic                rsp_valid,
   output logic                rsp_id,
   output logic [15:0]         rsp_data,
   input  logic                rsp_ready
);

   logic        can_accept;
   logic        gnt_valid;
   logic        gnt_id;
   logic        xfer;
   logic        xfer_lock;

   logic        last_q;
   logic        owned_q;
   logic        owner_q;
   logic        rsp_valid_q;
   logic        rsp_id_q;
   logic [15:0] rsp_data_q;

   assign can_accept = ~rsp_valid_q | rsp_ready;

   // Grant depends only on valids, response state and internal state, never on operands.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_id    = 1'b0;
      if (!reset && can_accept) begin
         if (owned_q) begin
            gnt_valid = owner_q ? req1_valid : req0_valid;
            gnt_id    = owner_q;
         end else if (req0_valid && req1_valid) begin
            gnt_valid = 1'b1;
            gnt_id    = ~last_q;
         end else if (req0_valid || req1_valid) begin
            gnt_valid = 1'b1;
            gnt_id    = req1_valid;
         end
      end
   end

   assign req0_ready = gnt_valid & ~gnt_id & req0_valid;
   assign req1_ready = gnt_valid &  gnt_id & req1_valid;
   assign xfer       = req0_ready | req1_ready;
   assign xfer_lock  = req1_ready ? req1_lock : req0_lock;

   // Requester 0 drives the ALU whenever requester 1 is not granted.
   always_comb begin
      if (gnt_valid && gnt_id) begin
         alu_a  = req1_a;
         alu_b  = req1_b;
         alu_op = req1_op;
      end else begin
         alu_a  = req0_a;
         alu_b  = req0_b;
         alu_op = req0_op;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q      <= 1'b1;
         owned_q     <= 1'b0;
         owner_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= 16'h0000;
      end else if (xfer) begin
         rsp_data_q  <= alu_out;
         rsp_id_q    <= req1_ready;
         rsp_valid_q <= 1'b1;
         last_q      <= req1_ready;
         owned_q     <= xfer_lock;
         owner_q     <= req1_ready;
      end else if (rsp_ready && rsp_valid_q) begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;

   one_ready_a: assert property (@(posedge clk) !(req0_ready && req1_ready));

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter against a rule-level model,
// preceded by directed single, contention, backpressure, lock and reset cases.
module tb_alu_arbiter;

   localparam logic [1:0] OpAdd = 2'd0, OpXor = 2'd1, OpAnd = 2'd2, OpSelB = 2'd3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rv[2];
   logic [15:0] ra[2];
   logic [15:0] rb[2];
   logic [1:0]  rop[2];
   logic        rlock[2];
   logic        req0_ready, req1_ready;
   logic [15:0] alu_a, alu_b, alu_out;
   logic [1:0]  alu_op;
   logic        rsp_valid, rsp_id, rsp_ready;
   logic [15:0] rsp_data;

   int n_vec = 0;
   int n_err = 0;
   int last_g = -1;

   // Reference model state
   bit          m_last = 1'b1, m_owned = 1'b0, m_owner = 1'b0, m_rv = 1'b0, m_rid = 1'b0;
   logic [15:0] m_rd = 16'h0000;

   always #5 clk = ~clk;

   function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                         input logic [1:0] op);
      case (op)
         OpAdd:   return a + b;
         OpXor:   return a ^ b;
         OpAnd:   return a & b;
         default: return b;
      endcase
   endfunction

   assign alu_out = alu_f(alu_a, alu_b, alu_op);

   alu_arbiter #(.OP_WIDTH(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (rv[0]),
      .req0_ready (req0_ready),
      .req0_a     (ra[0]),
      .req0_b     (rb[0]),
      .req0_op    (rop[0]),
      .req0_lock  (rlock[0]),
      .req1_valid (rv[1]),
      .req1_ready (req1_ready),
      .req1_a     (ra[1]),
      .req1_b     (rb[1]),
      .req1_op    (rop[1]),
      .req1_lock  (rlock[1]),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_out    (alu_out),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .rsp_ready  (rsp_ready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Who should win this cycle: -1 for nobody.
   function automatic int exp_grant();
      if (reset) return -1;
      if (m_rv && !rsp_ready) return -1;
      if (m_owned) return rv[m_owner] ? int'(m_owner) : -1;
      if (rv[0] && rv[1]) return m_last ? 0 : 1;
      if (rv[0]) return 0;
      if (rv[1]) return 1;
      return -1;
   endfunction

   task automatic cycle();
      int g;
      int s;
      @(negedge clk);
      g = exp_grant();
      s = (g < 0) ? 0 : g;
      check("ready0", 32'(req0_ready), 32'(g == 0));
      check("ready1", 32'(req1_ready), 32'(g == 1));
      check("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      check("rsp_id", 32'(rsp_id), 32'(m_rid));
      check("rsp_data", 32'(rsp_data), 32'(m_rd));
      check("alu_a", 32'(alu_a), 32'(ra[s]));
      check("alu_b", 32'(alu_b), 32'(rb[s]));
      check("alu_op", 32'(alu_op), 32'(rop[s]));
      @(posedge clk);
      if (reset) begin
         m_last = 1'b1; m_owned = 1'b0; m_owner = 1'b0;
         m_rv = 1'b0; m_rid = 1'b0; m_rd = 16'h0000;
      end else if (g >= 0) begin
         m_rd    = alu_f(ra[g], rb[g], rop[g]);
         m_rid   = 1'(g);
         m_rv    = 1'b1;
         m_last  = 1'(g);
         m_owned = rlock[g];
         m_owner = 1'(g);
      end else if (rsp_ready && m_rv) begin
         m_rv = 1'b0;
      end
      last_g = g;
      #1;
   endtask

   task automatic set_req(input int n, input logic v, input logic [15:0] a,
                          input logic [15:0] b, input logic [1:0] op, input logic lk);
      rv[n] = v; ra[n] = a; rb[n] = b; rop[n] = op; rlock[n] = lk;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   initial begin
      logic [15:0] hold_d;
      logic        hold_i;
      for (int n = 0; n < 2; n++) set_req(n, 1'b0, 16'h0, 16'h0, OpAdd, 1'b0);
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Single requester XOR
      set_req(0, 1'b1, 16'h1234, 16'h0F0F, OpXor, 1'b0);
      cycle();
      set_req(0, 1'b0, 16'h0, 16'h0, OpAdd, 1'b0);
      check("single_valid", 32'(rsp_valid), 32'd1);
      check("single_id", 32'(rsp_id), 32'd0);
      check("single_data", 32'(rsp_data), 32'h1D3B);
      cycle();

      // Contention alternates 0,1,0,1 after reset
      do_reset();
      set_req(0, 1'b1, 16'hFFFF, 16'h0001, OpAdd, 1'b0);
      set_req(1, 1'b1, 16'h8000, 16'h8001, OpAdd, 1'b0);
      for (int i = 0; i < 6; i++) begin
         cycle();
         check("cont_id", 32'(rsp_id), 32'(i % 2));
         if (i == 0) check("wrap_sum", 32'(rsp_data), 32'h0000);
         set_req(last_g < 0 ? 0 : last_g, 1'b1, 16'($urandom), 16'($urandom), OpAdd, 1'b0);
      end

      // Backpressure
      do_reset();
      set_req(0, 1'b1, 16'h0102, 16'h0304, OpAdd, 1'b0);
      set_req(1, 1'b1, 16'h1111, 16'h2222, OpXor, 1'b0);
      cycle();
      set_req(0, 1'b1, 16'h0005, 16'h0006, OpAnd, 1'b0);
      rsp_ready = 1'b0;
      hold_d = rsp_data;
      hold_i = rsp_id;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("bp_ready0", 32'(req0_ready), 32'd0);
         check("bp_ready1", 32'(req1_ready), 32'd0);
         check("bp_data", 32'(rsp_data), 32'(hold_d));
         check("bp_id", 32'(rsp_id), 32'(hold_i));
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_resume", 32'(req1_ready), 32'd1);
      cycle();
      check("bp_resume_data", 32'(rsp_data), 32'h3333);

      // Lock held by requester 1 across two ops while requester 0 waits
      do_reset();
      set_req(1, 1'b0, 16'h0, 16'h0, OpAdd, 1'b0);
      set_req(0, 1'b1, 16'h0001, 16'h0001, OpAdd, 1'b0);
      cycle();
      set_req(0, 1'b1, 16'h0A0A, 16'h0B0B, OpXor, 1'b0);
      set_req(1, 1'b1, 16'h1000, 16'h0234, OpAdd, 1'b1);
      cycle();
      check("lock_first", 32'(rsp_id), 32'd1);
      set_req(1, 1'b1, 16'hDEAD, 16'hBEEF, OpSelB, 1'b0);
      cycle();
      check("lock_second", 32'(rsp_id), 32'd1);
      check("lock_selb", 32'(rsp_data), 32'hBEEF);
      set_req(1, 1'b1, 16'h0003, 16'h0004, OpAdd, 1'b0);
      cycle();
      check("lock_release", 32'(rsp_id), 32'd0);

      // Lock with idle owner
      do_reset();
      set_req(1, 1'b0, 16'h0, 16'h0, OpAdd, 1'b0);
      set_req(0, 1'b1, 16'h0040, 16'h0002, OpAdd, 1'b1);
      cycle();
      set_req(0, 1'b0, 16'h0, 16'h0, OpAdd, 1'b0);
      set_req(1, 1'b1, 16'h5555, 16'h00FF, OpAnd, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("idle_owner_block", 32'(req1_ready), 32'd0);
         cycle();
      end
      set_req(0, 1'b1, 16'h0007, 16'h0008, OpAdd, 1'b0);
      cycle();
      check("idle_owner_resume", 32'(rsp_id), 32'd0);
      check("idle_owner_data", 32'(rsp_data), 32'h000F);

      // Reset mid-flight with pending response and ownership
      set_req(1, 1'b0, 16'h0, 16'h0, OpAdd, 1'b0);
      set_req(0, 1'b1, 16'h0100, 16'h0200, OpAdd, 1'b1);
      cycle();
      set_req(0, 1'b0, 16'h0, 16'h0, OpAdd, 1'b0);
      rsp_ready = 1'b0;
      do_reset();
      rsp_ready = 1'b1;
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      set_req(1, 1'b1, 16'h0011, 16'h0022, OpAdd, 1'b0);
      #1;
      check("rst_owned_clear", 32'(req1_ready), 32'd1);
      set_req(0, 1'b1, 16'h0033, 16'h0044, OpAdd, 1'b0);
      #1;
      check("rst_first_gnt0", 32'(req0_ready), 32'd1);
      cycle();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         for (int n = 0; n < 2; n++) begin
            if (!rv[n] || last_g == n) begin
               set_req(n, ($urandom % 4) != 0,
                       ($urandom % 8 == 0) ? 16'hFFFF : 16'($urandom),
                       16'($urandom), 2'($urandom), ($urandom % 4) == 0);
            end
         end
         rsp_ready = ($urandom % 4) != 0;
         reset     = ($urandom % 100) == 0;
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
